// File: rtl/arvi_pkg.sv
// arvi_pkg: shared writeback-stage types, constants and the write-value select helper
package arvi_pkg;
  localparam int WB_XLEN = 32;
  localparam logic [4:0] REG_X0 = 5'd0;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;
  typedef struct packed {
    logic valid;
    logic we;
    logic [4:0] waddr;
    logic [WB_XLEN-1:0] wdata;
  } memwb_t;
  function automatic wb_sel_e wb_sel(input logic pcplus4, input logic memtoreg);
    return pcplus4 ? WB_PC4 : memtoreg ? WB_MEM : WB_ALU;
  endfunction
endpackage

// File: rtl/retire_counter.sv
// retire_counter: free-running event counter with synchronous clear that beats increment
module retire_counter #(
  parameter int W = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);
  // clear wins over a same-edge increment; the count wraps naturally
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) o_count <= '0;
    else if (i_clr) o_count <= '0;
    else if (i_inc) o_count <= o_count + W'(1);
endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB register, write-value select, register-file port, forwarding tap and retire count
module wb_stage
  import arvi_pkg::*;
#(
  parameter int XLEN  = WB_XLEN,
  parameter int CNT_W = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_stall,
  input  logic             i_exception,
  input  logic [31:0]      i_inst,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [XLEN-1:0]  i_alu_res,
  input  logic [XLEN-1:0]  i_rd,
  input  logic             i_mc_memtoreg,
  input  logic             i_mc_regwrite,
  input  logic             i_mc_pcplus4,
  input  logic             i_cnt_clr,
  output logic             o_rf_we,
  output logic [4:0]       o_rf_waddr,
  output logic [XLEN-1:0]  o_rf_wdata,
  output logic             o_fwd_valid,
  output logic [4:0]       o_fwd_addr,
  output logic [XLEN-1:0]  o_fwd_data,
  output logic             o_retired,
  output logic [CNT_W-1:0] o_instret
);
  memwb_t wb;
  wb_sel_e sel;
  logic [XLEN-1:0] wval;
  logic cap, retire;
  logic unused_inst;
  assign unused_inst = &{1'b0, i_inst[31:12], i_inst[6:0]};
  assign sel = wb_sel(i_mc_pcplus4, i_mc_memtoreg);
  assign cap = i_valid & ~i_stall;
  assign retire = cap & ~i_exception;
  // pick the value to write back: PC+4 for links, then load/CSR data, then ALU
  always_comb wval = sel == WB_PC4 ? i_pc + XLEN'(4) : sel == WB_MEM ? i_rd : i_alu_res;
  // capture one instruction per unstalled valid cycle, otherwise insert a bubble
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      wb <= '0;
      o_retired <= 1'b0;
    end else begin
      wb.valid <= cap;
      wb.we <= cap & i_mc_regwrite & ~i_exception & (i_inst[11:7] != REG_X0);
      o_retired <= retire;
      if (cap) begin
        wb.waddr <= i_inst[11:7];
        wb.wdata <= WB_XLEN'(wval);
      end
    end
  assign o_rf_we = wb.valid & wb.we;
  assign o_rf_waddr = wb.waddr;
  assign o_rf_wdata = XLEN'(wb.wdata);
  assign o_fwd_valid = o_rf_we;
  assign o_fwd_addr = o_rf_waddr;
  assign o_fwd_data = o_rf_wdata;
  retire_counter #(.W(CNT_W)) u_cnt (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_inc(retire),
    .i_clr(i_cnt_clr),
    .o_count(o_instret)
  );
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: randomized and directed checks of wb_stage against a behavioural model
module tb_wb_stage;
  logic clk = 1'b0, rst = 1'b0;
  logic valid = 0, stall = 0, exc = 0, mem = 0, rw = 0, pc4 = 0, clr = 0;
  logic [31:0] inst = '0, pc = '0, alu = '0, rdata = '0;
  logic rf_we, fwd_valid, retired;
  logic [4:0] rf_waddr, fwd_addr;
  logic [31:0] rf_wdata, fwd_data;
  logic [63:0] instret;
  logic rf_we4, fwd_valid4, retired4;
  logic [4:0] rf_waddr4, fwd_addr4;
  logic [31:0] rf_wdata4, fwd_data4;
  logic [3:0] instret4;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_stall(stall), .i_exception(exc),
    .i_inst(inst), .i_pc(pc), .i_alu_res(alu), .i_rd(rdata), .i_mc_memtoreg(mem),
    .i_mc_regwrite(rw), .i_mc_pcplus4(pc4), .i_cnt_clr(clr),
    .o_rf_we(rf_we), .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata),
    .o_fwd_valid(fwd_valid), .o_fwd_addr(fwd_addr), .o_fwd_data(fwd_data),
    .o_retired(retired), .o_instret(instret)
  );

  // narrow counter instance so wrap-around is reachable in simulation
  wb_stage #(.CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_stall(stall), .i_exception(exc),
    .i_inst(inst), .i_pc(pc), .i_alu_res(alu), .i_rd(rdata), .i_mc_memtoreg(mem),
    .i_mc_regwrite(rw), .i_mc_pcplus4(pc4), .i_cnt_clr(clr),
    .o_rf_we(rf_we4), .o_rf_waddr(rf_waddr4), .o_rf_wdata(rf_wdata4),
    .o_fwd_valid(fwd_valid4), .o_fwd_addr(fwd_addr4), .o_fwd_data(fwd_data4),
    .o_retired(retired4), .o_instret(instret4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic exp_we = 0, exp_ret = 0;
  logic [4:0] exp_addr = '0;
  logic [31:0] exp_data = '0;
  logic [63:0] exp_cnt = '0;
  logic [3:0] exp_cnt4 = '0;

  // reference model: what WB must hold after each edge, from the stage's rules
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_we = 0; exp_ret = 0; exp_addr = '0; exp_data = '0; exp_cnt = '0; exp_cnt4 = '0;
    end else begin
      exp_ret = valid && !stall && !exc;
      exp_we = valid && !stall && !exc && rw && (inst[11:7] != 5'd0);
      if (valid && !stall) begin
        exp_addr = inst[11:7];
        exp_data = pc4 ? pc + 32'd4 : (mem ? rdata : alu);
      end
      exp_cnt = clr ? 64'd0 : exp_cnt + {63'd0, exp_ret};
      exp_cnt4 = clr ? 4'd0 : exp_cnt4 + {3'd0, exp_ret};
    end
  end

  // compare every cycle away from the capture edge
  always @(negedge clk) begin
    chk("rf_we", {63'd0, rf_we}, {63'd0, exp_we});
    chk("fwd_valid", {63'd0, fwd_valid}, {63'd0, exp_we});
    chk("retired", {63'd0, retired}, {63'd0, exp_ret});
    chk("instret", instret, exp_cnt);
    chk("instret4", {60'd0, instret4}, {60'd0, exp_cnt4});
    if (exp_we || !rst) begin
      chk("rf_waddr", {59'd0, rf_waddr}, {59'd0, exp_addr});
      chk("rf_wdata", {32'd0, rf_wdata}, {32'd0, exp_data});
      chk("fwd_addr", {59'd0, fwd_addr}, {59'd0, exp_addr});
      chk("fwd_data", {32'd0, fwd_data}, {32'd0, exp_data});
    end
  end

  task automatic step(input logic v, s, e, w, m, p, c, input logic [4:0] rd,
                      input logic [31:0] a, d, pcv);
    valid = v; stall = s; exc = e; rw = w; mem = m; pc4 = p; clr = c;
    inst = {20'hA5A5A, rd, 7'h33}; alu = a; rdata = d; pc = pcv;
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] c0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0, 0, 0, 5'd9, 32'h55 + i, 0, 0);
    chk("rst_held_we", {63'd0, rf_we}, 64'd0);
    chk("rst_held_data", {32'd0, rf_wdata}, 64'd0);
    #2 rst = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_instret", instret, 64'd0);
    step(1, 0, 0, 1, 0, 0, 0, 5'd5, 32'h0000_1234, 0, 0);
    chk("alu_we", {63'd0, rf_we}, 64'd1);
    chk("alu_addr", {59'd0, rf_waddr}, 64'd5);
    chk("alu_data", {32'd0, rf_wdata}, 64'h1234);
    chk("alu_fwd", {27'd0, fwd_valid, fwd_addr, fwd_data}, {27'd0, 1'b1, 5'd5, 32'h1234});
    chk("alu_ret", {63'd0, retired}, 64'd1);
    chk("alu_cnt", instret, 64'd1);
    step(1, 0, 0, 1, 1, 1, 0, 5'd6, 32'h1111, 32'h2222, 32'hFFFF_FFFC);
    chk("pc4_wrap", {32'd0, rf_wdata}, 64'd0);
    step(1, 0, 0, 1, 1, 0, 0, 5'd6, 32'h1111, 32'hDEAD_BEEF, 32'h100);
    chk("memtoreg", {32'd0, rf_wdata}, 64'hDEAD_BEEF);
    step(1, 0, 0, 1, 0, 0, 0, 5'd0, 32'h77, 0, 0);
    chk("x0_we", {63'd0, rf_we}, 64'd0);
    chk("x0_ret", {63'd0, retired}, 64'd1);
    c0 = instret;
    step(1, 0, 1, 1, 0, 0, 0, 5'd7, 32'h88, 0, 0);
    chk("exc_we", {63'd0, rf_we}, 64'd0);
    chk("exc_ret", {63'd0, retired}, 64'd0);
    chk("exc_cnt", instret, c0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 1, 0, 0, 0, 5'd8, 32'h99, 0, 0);
      chk("stall_we", {63'd0, rf_we}, 64'd0);
      chk("stall_ret", {63'd0, retired}, 64'd0);
    end
    step(1, 0, 0, 1, 0, 0, 0, 5'd8, 32'h99, 0, 0);
    chk("stall_wr", {27'd0, rf_we, rf_waddr, rf_wdata}, {27'd0, 1'b1, 5'd8, 32'h99});
    chk("stall_cnt", instret, c0 + 64'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("idle_we", {63'd0, rf_we}, 64'd0);
    step(1, 0, 0, 1, 0, 0, 0, 5'd3, 32'hAAAA, 0, 0);
    chk("b2b_a", {32'd0, rf_wdata}, 64'hAAAA);
    step(1, 0, 0, 1, 0, 0, 0, 5'd3, 32'hBBBB, 0, 0);
    chk("b2b_b", {27'd0, rf_we, rf_waddr, rf_wdata}, {27'd0, 1'b1, 5'd3, 32'hBBBB});
    step(1, 0, 0, 1, 0, 0, 1, 5'd4, 32'h1, 0, 0);
    chk("clr_cnt", instret, 64'd0);
    chk("clr_ret", {63'd0, retired}, 64'd1);
    for (int i = 0; i < 16; i++) step(1, 0, 0, 1, 0, 0, 0, 5'd2, i, 0, 0);
    chk("wrap4", {60'd0, instret4}, 64'd0);
    chk("cnt16", instret, 64'd16);
    step(1, 0, 0, 1, 0, 0, 0, 5'd2, 32'h5, 0, 0);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("midrst_we", {63'd0, rf_we}, 64'd0);
    chk("midrst_cnt", instret, 64'd0);
    #2 rst = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
           $urandom_range(0, 49) == 0, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
           $urandom, $urandom, ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage; sits directly downstream of the memory-access stage.
- Registers that stage's results into a MEM/WB pipeline register and selects the register-file write data (ALU result, load/CSR read data, or PC+4).
- Drives the register-file write port and presents a forwarding tap for the execute stage.
- Cancels register writes for excepting instructions and keeps a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset; asynchronous, active-low (0 = reset asserted).
- i_valid  in  1  memory stage holds a real instruction this cycle.
- i_stall  in  1  memory stage stalled (data-memory wait).
- i_exception  in  1  memory-stage instruction raised an exception.
- i_inst  in  32  instruction word; rd field is i_inst[11:7].
- i_pc  in  XLEN  PC of the instruction.
- i_alu_res  in  XLEN  ALU result.
- i_rd  in  XLEN  load or CSR read data.
- i_mc_memtoreg  in  1  select i_rd as the write value.
- i_mc_regwrite  in  1  instruction writes rd.
- i_mc_pcplus4  in  1  select PC+4 as the write value (JAL/JALR).
- i_cnt_clr  in  1  synchronous clear of the retire counter.
- o_rf_we  out  1  register-file write enable.
- o_rf_waddr  out  5  register-file write address.
- o_rf_wdata  out  XLEN  register-file write data.
- o_fwd_valid  out  1  forwarding tap holds a pending write.
- o_fwd_addr  out  5  forwarding destination register.
- o_fwd_data  out  XLEN  forwarding value.
- o_retired  out  1  one-cycle pulse when an instruction retires.
- o_instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (i_rst=0, asynchronous):
  - WB register valid=0; we=0; waddr=0; wdata=0.
  - o_retired=0; o_instret=0.
  - Every output reads 0 while reset is held.
  - Reset mid-operation discards the captured instruction; no write issues.
- Capture on each rising edge:
  - If i_valid=1 and i_stall=0, load the WB register from the inputs.
  - Otherwise load a bubble: valid=0, we=0. The addr/data registers may hold their old values.
  - A stall therefore yields exactly one bubble per stalled cycle. The same instruction is never captured twice.
- Write-value select, computed before the register (registered value):
  - Priority: pcplus4 selects i_pc+4 (modulo 2^XLEN).
  - Else memtoreg selects i_rd.
  - Else i_alu_res.
- Write-enable at capture: we = i_mc_regwrite AND NOT i_exception AND (i_inst[11:7] != 0).
  - Writes to x0 are never issued.
  - Excepting instructions are captured with valid=1 but we=0.
- Outputs are driven directly from the WB register:
  - o_rf_we = valid AND we.
  - o_rf_waddr and o_rf_wdata come from the register.
  - Latency is 1 cycle from the capture edge to the visible write; the register file writes on the following edge.
- Forwarding tap: o_fwd_valid = o_rf_we; o_fwd_addr = o_rf_waddr; o_fwd_data = o_rf_wdata (same cycle).
- Retirement:
  - An instruction retires when it is captured with i_valid=1, i_stall=0 and i_exception=0 (ECALL excepts, so it does not retire).
  - o_retired is registered and aligned with the WB register: high for exactly the cycle the retiring instruction occupies WB.
- Counter:
  - o_instret increments by 1 on the same edge that sets o_retired. Equivalently, o_instret reflects all retirements up to and including the instruction currently in WB.
  - Wraps from all-ones to 0.
- Clear/retire collisions:
  - i_cnt_clr=1 on an edge forces o_instret=0.
  - Clear and a simultaneous retirement give 0; clear wins, and that retirement is not counted.
  - o_retired still pulses in that case.
- Back-to-back writes to the same rd: each is presented in turn, with no merging.

Decomposition:
- Shared package arvi_pkg:
  - enum wb_sel_e {WB_ALU, WB_MEM, WB_PC4}.
  - constant REG_X0 = 5'd0.
  - typedef memwb_t, a struct holding valid, we, waddr and wdata.
- One sub-module, retire_counter:
  - Contains the CNT_W-bit counter with its increment and clear.
  - Same clock/reset convention.
  - Makes the counter reusable for a future cycle counter.

Test Plan:
- Reset: hold i_rst=0 while driving valid ALU ops. All outputs stay 0. After release, o_instret=0.
- ALU write: i_valid=1, regwrite=1, rd=5, alu_res=0x0000_1234. On the next cycle o_rf_we=1, waddr=5, wdata=0x1234, o_retired=1, o_instret=1. o_fwd_* match.
- Select priority:
  - pcplus4=1 and memtoreg=1 with pc=0xFFFF_FFFC gives wdata=0x0000_0000 (wrap).
  - memtoreg alone with i_rd=0xDEAD_BEEF gives wdata=0xDEADBEEF.
- x0 and exception:
  - rd=0 with regwrite=1 gives o_rf_we=0, o_retired=1.
  - rd=7 with i_exception=1 gives o_rf_we=0, o_retired=0, counter unchanged.
- Stall: i_valid=1 with i_stall=1 for 3 cycles, then 0. Exactly 3 bubble cycles (we=0, retired=0), then one write. Counter increments by 1.
- Counter edges:
  - Preload to 2^64-1 via 2^64-1 forced retirements, or a backdoor force; one more retirement gives 0.
  - i_cnt_clr coinciding with a retirement gives o_instret=0 and o_retired=1.
